// File: rtl/lock_pkg.sv
// Shared types and default constants for the sequence-lock front end.
// The button FSM state encoding lives here so every stage decodes it the same way.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RISE_CHK = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_FALL_CHK = 2'd3
  } btn_state_t;

  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_DEBOUNCE_CYCLES   = 16;
  localparam int DEF_LONG_PRESS_CYCLES = 1024;

endpackage

// File: rtl/bit_synchronizer.sv
// N-flop synchroniser for a single asynchronous bit.
// The flops reset to 0, and the output is taken from the last stage.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces a raw push-button.
// Produces a clean level plus one-cycle press, release and long-press pulses.
module button_conditioner
  import lock_pkg::*;
#(
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_clean,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int CNT_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic btn_s;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (btn_s)
  );

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] lp_cnt_q, lp_cnt_d;
  logic             clean_q, clean_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             lp_run;

  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    lp_cnt_d  = lp_cnt_q;
    clean_d   = clean_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    lp_run    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clean_d  = 1'b0;
        lp_cnt_d = '0;
        if (btn_s) begin
          state_d  = ST_RISE_CHK;
          db_cnt_d = ONE;
        end
      end
      ST_RISE_CHK: begin
        if (!btn_s) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = ST_PRESSED;
          clean_d  = 1'b1;
          press_d  = 1'b1;
          db_cnt_d = '0;
          lp_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + ONE;
        end
      end
      ST_PRESSED: begin
        lp_run = 1'b1;
        if (!btn_s) begin
          state_d  = ST_FALL_CHK;
          db_cnt_d = ONE;
        end
      end
      ST_FALL_CHK: begin
        // The button is still considered held here, so the long-press count keeps running.
        lp_run = 1'b1;
        if (btn_s) begin
          state_d  = ST_PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_IDLE;
          clean_d   = 1'b0;
          release_d = 1'b1;
          db_cnt_d  = '0;
          lp_run    = 1'b0;
          lp_cnt_d  = '0;
        end else begin
          db_cnt_d = db_cnt_q + ONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        clean_d  = 1'b0;
        db_cnt_d = '0;
        lp_cnt_d = '0;
      end
    endcase

    // Saturating at LP_MAX ensures LP_LAST is matched only once per press.
    if (lp_run) begin
      if (lp_cnt_q == LP_LAST) long_d = 1'b1;
      if (lp_cnt_q != LP_MAX)  lp_cnt_d = lp_cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      db_cnt_q  <= '0;
      lp_cnt_q  <= '0;
      clean_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      lp_cnt_q  <= lp_cnt_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign btn_clean     = clean_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and random stimulus for button_conditioner.
// Checks against a run-length model of the synchronised button.
module tb_button_conditioner;

  localparam int SS = 2;
  localparam int DB = 4;
  localparam int LP = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_clean, press_pulse, release_pulse, long_pulse;

  int vectors = 0;
  int miscompares = 0;

  // Model state: raw samples from the last two edges, the accepted level,
  // the current run of disagreeing samples, and how long the press has been accepted.
  bit h0, h1, m_clean;
  int run, age;
  bit ep, er, el;
  int n_press, n_release, n_long;

  button_conditioner #(
    .SYNC_STAGES       (SS),
    .DEBOUNCE_CYCLES   (DB),
    .LONG_PRESS_CYCLES (LP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .btn_clean     (btn_clean),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    h0 = 0; h1 = 0; m_clean = 0; run = 0; age = 0;
    ep = 0; er = 0; el = 0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".clean"},   int'(btn_clean),     int'(m_clean));
    chk({tag, ".press"},   int'(press_pulse),   int'(ep));
    chk({tag, ".release"}, int'(release_pulse), int'(er));
    chk({tag, ".long"},    int'(long_pulse),    int'(el));
  endtask

  task automatic tick(input bit r, input string tag);
    bit s;
    btn_raw = r;
    @(posedge clk);
    if (rst_n) begin
      s  = h1;
      h1 = h0;
      h0 = r;
      ep = 0; er = 0; el = 0;
      if (s != m_clean) run++;
      else run = 0;
      if (run == DB) begin
        m_clean = !m_clean;
        run = 0;
        if (m_clean) begin ep = 1; age = 0; end
        else er = 1;
      end else if (m_clean) begin
        age++;
        if (age == LP) el = 1;
      end
    end
    #1;
    if (press_pulse)   n_press++;
    if (release_pulse) n_release++;
    if (long_pulse)    n_long++;
    chk_outs(tag);
  endtask

  task automatic hold(input bit r, input int n, input string tag);
    for (int i = 0; i < n; i++) tick(r, tag);
  endtask

  initial begin
    int p0, r0, l0, t_press;
    bit lvl;
    model_clear();
    n_press = 0; n_release = 0; n_long = 0;

    // Reset held with the button pressed
    btn_raw = 1'b1;
    #2;
    chk_outs("reset");
    hold(1, 3, "in_reset");
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1, "post_reset");
      if (i == 5) chk("post_reset.clean_c5", int'(btn_clean), 0);
      if (i == 6) chk("post_reset.clean_c6", int'(btn_clean), 1);
    end
    hold(0, 10, "post_reset_fall");

    // Clean press
    p0 = n_press; r0 = n_release; l0 = n_long;
    hold(1, 8, "clean_hi");
    hold(0, 12, "clean_lo");
    chk("clean.press_cnt", n_press - p0, 1);
    chk("clean.release_cnt", n_release - r0, 1);
    chk("clean.long_cnt", n_long - l0, 0);

    // Bounce
    p0 = n_press;
    tick(1, "bounce"); tick(0, "bounce"); tick(1, "bounce");
    tick(1, "bounce"); tick(0, "bounce"); tick(1, "bounce");
    hold(0, 8, "bounce_lo");
    chk("bounce.press_cnt", n_press - p0, 0);

    // Long press
    l0 = n_long; t_press = -1;
    for (int i = 0; i < 40; i++) begin
      tick(1, "long_hi");
      if (press_pulse) t_press = i;
      if (long_pulse) chk("long.delay", i - t_press, LP);
    end
    hold(0, 12, "long_lo");
    chk("long.long_cnt", n_long - l0, 1);

    // Short low blip during a held press
    r0 = n_release; l0 = n_long; t_press = -1;
    for (int i = 0; i < 30; i++) begin
      tick((i == 8 || i == 9) ? 1'b0 : 1'b1, "glitch");
      if (press_pulse) t_press = i;
      if (long_pulse) chk("glitch.long_delay", i - t_press, LP);
    end
    chk("glitch.release_cnt", n_release - r0, 0);
    hold(0, 12, "glitch_lo");
    chk("glitch.long_cnt", n_long - l0, 1);

    // Reset while the press is accepted
    hold(1, 8, "midrst_hi");
    chk("midrst.clean_before", int'(btn_clean), 1);
    r0 = n_release;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk_outs("midrst_async");
    hold(1, 2, "midrst_in");
    rst_n = 1'b1;
    hold(1, 8, "midrst_repress");
    chk("midrst.release_cnt", n_release - r0, 0);
    hold(0, 12, "midrst_lo");

    // Random segments
    for (int seg = 0; seg < 80; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      hold(lvl, $urandom_range(1, 14), "random");
    end
    hold(0, 20, "random_tail");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
